mod_sub: RTL and testbench
==========================

// Module: mod_sub
// PURPOSE
//   Sequential modular subtractor: r = (a - b) mod p, the inverse companion of the modular adder.
//   Accepts unreduced operands (0 <= a,b < 2^width), reduces both in parallel by
//   shift-and-subtract, then subtracts with a conditional +p correction.
//   Used by point-add/double datapaths for field subtraction; start/done handshake matches adder.
// PARAMETERS
//   p      37   modulus; 2 <= p < 2^width
//   width  128  operand/result width in bits
// PORTS
//   clk     in   1      clock, all state on rising edge
//   reset   in   1      asynchronous, active-low reset
//   enable  in   1      start request; sampled only in IDLE
//   a       in   width  minuend, captured on accepted start
//   b       in   width  subtrahend, captured on accepted start
//   r       out  width  result, (a - b) mod p, held until next done
//   done    out  1      one-cycle pulse, r valid in same cycle
//   busy    out  1      high in REDUCE and SUB states
// BEHAVIOUR
//   - Reset (reset==0, async): state=IDLE, r=0, done=0, busy=0, internal regs cleared.
//   - States: IDLE -> REDUCE -> SUB -> IDLE.
//   - IDLE: if enable, latch ra=a, rb=b, k=width-1, go REDUCE. Else hold; done=0.
//   - REDUCE: one step per cycle, k = width-1 down to 0:
//       ra -= (p<<k) if ra >= (p<<k); same for rb, both in parallel.
//       Comparisons are done at 2*width bits, so p<<k never truncates.
//       After k=0 step go SUB. Invariant on exit: ra < p, rb < p.
//   - SUB: d = ra - rb (width+1 bits); r <= d[width] ? d+p : d (low width bits);
//       done <= 1 for exactly one cycle; go IDLE.
//   - Latency: edge sampling enable = edge 0; r/done updated at edge width+1.
//       Fixed, data independent; 129 cycles at default width.
//   - enable while busy: ignored, not queued; captured a/b are unaffected.
//   - enable high in the cycle done is high: state is IDLE, so the request is accepted.
//       Back-to-back throughput is one result per width+2 cycles.
//   - enable held high: a new operation starts every width+2 cycles.
//   - a == b yields r = 0; b > a wraps correctly (r = a - b + p, after reduction).
//   - Reset mid-operation: aborts immediately; no done pulse; next start begins clean.
//   - r is never cleared except by reset; it changes only at a done edge.
// CONFIGURATION
//   MODSUB_FAST_EN defined:
//     In IDLE on accepted start, if a < p and b < p, skip REDUCE and go straight to SUB.
//     Latency is then 1 (done at edge 1); otherwise behaviour is unchanged.
//   MODSUB_FAST_EN undefined:
//     Always traverse REDUCE; fixed latency width+1; no input comparators in IDLE.
// TESTING (p=37, width=128 unless noted)
//   1. a=10, b=3, one-cycle enable -> done pulse at edge 129, r=7, busy low after.
//   2. a=3, b=10 -> r=30; a=b=100 -> r=0.
//   3. a=2^128-1, b=0 -> r=32; a=0, b=2^128-1 -> r=5.
//   4. start a=10,b=3; pulse enable with a=1,b=2 at edge 50 -> single done at 129, r=7;
//      no second done.
//   5. start, assert reset low at edge 60 for 2 cycles -> r=0, done never pulses;
//      restart a=40,b=1 -> r=2.
//   6. MODSUB_FAST_EN defined: a=5, b=9 -> done at edge 1, r=33;
//      a=40, b=1 -> slow path, done at edge 129, r=2.

Source files
------------

// File: rtl/mod_sub_if.sv
// Operand/result bundle for the sequential modular subtractor.
// Master drives the start request and operands; slave returns result and status.
// done is a one-cycle pulse; busy marks the window where enable is ignored.
interface mod_sub_if #(
  parameter int unsigned width = 128
);
  logic             enable;
  logic [width-1:0] a;
  logic [width-1:0] b;
  logic [width-1:0] r;
  logic             done;
  logic             busy;

  modport master (
    output enable, a, b,
    input  r, done, busy
  );

  modport slave (
    input  enable, a, b,
    output r, done, busy
  );
endinterface

// File: rtl/mod_sub.sv
// Sequential modular subtractor r = (a - b) mod p on unreduced width-bit operands.
// Latency width+1 cycles from the accepted enable edge (1 cycle on the fast path).
// enable is ignored while busy; no queueing. Optional macro: MODSUB_FAST_EN.
module mod_sub #(
  parameter int unsigned p     = 37,
  parameter int unsigned width = 128
) (
  input logic     clk,
  input logic     reset,
  mod_sub_if.slave bus
);

  localparam int unsigned KW = (width > 1) ? $clog2(width) : 1;
  localparam int unsigned WW = 2 * width;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REDUCE = 2'd1;
  localparam logic [1:0] SUB    = 2'd2;

  // Modulus at operand width and at double width; the double-width copy lets
  // p<<k be formed for every k without losing high bits.
  localparam logic [width-1:0] P_N    = width'(p);
  localparam logic [WW-1:0]    P_WIDE = WW'(p);

  logic [1:0]       state;
  logic [width-1:0] ra;
  logic [width-1:0] rb;
  logic [KW-1:0]    k;
  logic [width-1:0] r_q;
  logic             done_q;

  logic [WW-1:0]    p_sh;
  logic             ra_ge;
  logic             rb_ge;
  logic [width:0]   diff;
  logic [width-1:0] sub_res;
  logic             go_fast;

  assign p_sh  = P_WIDE << k;
  // When ra >= p<<k the shifted modulus is below 2^width, so its low half
  // carries the whole value and the subtraction below is exact.
  assign ra_ge = ({{width{1'b0}}, ra} >= p_sh);
  assign rb_ge = ({{width{1'b0}}, rb} >= p_sh);

  // Both operands are already below p here, so one +p correction suffices.
  assign diff    = {1'b0, ra} - {1'b0, rb};
  assign sub_res = diff[width] ? (diff[width-1:0] + P_N) : diff[width-1:0];

`ifdef MODSUB_FAST_EN
  // Operands already reduced: the REDUCE walk would be a no-op, skip it.
  assign go_fast = (bus.a < P_N) && (bus.b < P_N);
`else
  assign go_fast = 1'b0;
`endif

  assign bus.r    = r_q;
  assign bus.done = done_q;
  assign bus.busy = (state != IDLE);

  // Control FSM plus the parallel shift-and-subtract reduction datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      k      <= '0;
      r_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable) begin
            ra    <= bus.a;
            rb    <= bus.b;
            k     <= KW'(width - 1);
            state <= go_fast ? SUB : REDUCE;
          end
        end
        REDUCE: begin
          if (ra_ge) ra <= ra - p_sh[width-1:0];
          if (rb_ge) rb <= rb - p_sh[width-1:0];
          if (k == '0) begin
            state <= SUB;
          end else begin
            k <= k - KW'(1);
          end
        end
        SUB: begin
          r_q    <= sub_res;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_sub.sv
// Self-checking bench for mod_sub: directed corner cases plus randomized
// operands compared against an arithmetic reference (a mod p - b mod p, wrapped).
// Latency is measured in clock edges from the edge that accepts enable.
module tb_mod_sub;

  localparam int unsigned P = 37;
  localparam int unsigned W = 128;
`ifdef MODSUB_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mod_sub_if #(.width(W)) bus();

  mod_sub #(.p(P), .width(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] xm, ym;
    xm = x % W'(P);
    ym = y % W'(P);
    return (xm >= ym) ? (xm - ym) : (xm + W'(P) - ym);
  endfunction

  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
    return (FAST && (x < W'(P)) && (y < W'(P))) ? 1 : int'(W) + 1;
  endfunction

  function automatic logic [W-1:0] rnd_wide();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Count edges until done is seen; 0 means the bound expired.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    int lat;
    @(negedge clk);
    bus.a = x; bus.b = y; bus.enable = 1'b1;
    @(posedge clk); #1;
    bus.enable = 1'b0;
    check({tag, "_busy"}, W'(bus.busy), W'(1));
    wait_done(lat);
    check({tag, "_lat"}, W'(lat), W'(exp_lat(x, y)));
    check({tag, "_r"}, bus.r, model(x, y));
    @(posedge clk); #1;
    check({tag, "_done_once"}, W'(bus.done), W'(0));
    check({tag, "_idle"}, W'(bus.busy), W'(0));
    check({tag, "_r_held"}, bus.r, model(x, y));
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] x, y;
    int n_done, first_done, lat;
    ones = '1;

    // Reset state
    reset = 1'b0; bus.enable = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_r", bus.r, W'(0));
    check("rst_done", W'(bus.done), W'(0));
    check("rst_busy", W'(bus.busy), W'(0));
    @(negedge clk); reset = 1'b1;

    // Directed values
    run_op("t1", W'(10), W'(3));
    run_op("t2_wrap", W'(3), W'(10));
    run_op("t2_eq", W'(100), W'(100));
    run_op("t3_max_a", ones, W'(0));
    run_op("t3_max_b", W'(0), ones);
    run_op("t6_small", W'(5), W'(9));
    run_op("t6_big", W'(40), W'(1));

    // enable while busy is ignored and operands already captured stay intact
    @(negedge clk);
    bus.a = W'(10); bus.b = W'(3); bus.enable = 1'b1;
    @(posedge clk); #1;
    bus.enable = 1'b0;
    n_done = 0; first_done = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (i == 49) begin bus.a = W'(1); bus.b = W'(2); bus.enable = 1'b1; end
      if (i == 50) bus.enable = 1'b0;
      if (bus.done) begin
        n_done++;
        if (first_done == 0) first_done = i;
      end
    end
    check("t4_ndone", W'(n_done), W'(1));
    check("t4_lat", W'(first_done), W'(W + 1));
    check("t4_r", bus.r, W'(7));

    // Reset mid-operation aborts with no done pulse
    @(negedge clk);
    bus.a = W'(10); bus.b = W'(3); bus.enable = 1'b1;
    @(posedge clk); #1;
    bus.enable = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("t5_rst_r", bus.r, W'(0));
    check("t5_rst_busy", W'(bus.busy), W'(0));
    repeat (2) @(posedge clk);
    #1;
    check("t5_rst_done", W'(bus.done), W'(0));
    reset = 1'b1;
    n_done = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (bus.done) n_done++;
    end
    check("t5_no_done", W'(n_done), W'(0));
    check("t5_r_cleared", bus.r, W'(0));
    run_op("t5_restart", W'(40), W'(1));

    // Randomized operands
    for (int n = 0; n < 10; n++) begin
      case ($urandom_range(0, 3))
        0: begin x = rnd_wide(); y = rnd_wide(); end
        1: begin x = W'($urandom_range(0, 60)); y = W'($urandom_range(0, 60)); end
        2: begin x = W'($urandom_range(0, 60)); y = rnd_wide(); end
        default: begin x = rnd_wide(); y = x; end
      endcase
      run_op($sformatf("rnd%0d", n), x, y);
    end

    // enable held high: one result per (latency + 1) edges, operands per done
    qa.push_back(rnd_wide());       qb.push_back(rnd_wide());
    qa.push_back(W'(5));            qb.push_back(W'(9));
    qa.push_back(W'(2));            qb.push_back(rnd_wide());
    qa.push_back(rnd_wide());       qb.push_back(W'(36));
    @(negedge clk);
    bus.a = qa[0]; bus.b = qb[0]; bus.enable = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) begin
      wait_done(lat);
      check($sformatf("b2b%0d_gap", j), W'(lat),
            W'((j == 0) ? exp_lat(qa[j], qb[j]) : exp_lat(qa[j], qb[j]) + 1));
      check($sformatf("b2b%0d_r", j), bus.r, model(qa[j], qb[j]));
      if (j < 3) begin
        bus.a = qa[j+1]; bus.b = qb[j+1];
      end else begin
        bus.enable = 1'b0;
      end
    end
    @(posedge clk); #1;
    check("b2b_idle", W'(bus.busy), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
